// File: rtl/fifo_stream_packer.sv
// Read-side FIFO consumer: packs G_RATIO words into one wide word and presents
// it through a 2-entry in-order output buffer on a valid/ready stream.
module fifo_stream_packer #(
    parameter int G_WIDTH = 8,
    parameter int G_RATIO = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    output logic                         o_fifo_rd,
    input  logic                         i_fifo_empty,
    input  logic [G_WIDTH-1:0]           i_fifo_data,
    input  logic                         i_fifo_rd_done,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [G_WIDTH*G_RATIO-1:0]   o_data,
    output logic [1:0]                   o_level,
    output logic                         o_err
);

    localparam int DW = G_WIDTH * G_RATIO;
    localparam int PW = (G_RATIO > 1) ? $clog2(G_RATIO) : 1;
    localparam int CW = $clog2(2 * G_RATIO + 2);
    localparam logic [PW-1:0] LAST    = PW'(G_RATIO - 1);
    localparam logic [CW-1:0] RATIO_C = CW'(G_RATIO);
    localparam logic [CW-1:0] LIMIT   = CW'(2 * G_RATIO);

    logic [PW-1:0] pack_cnt;
    logic          inflight;
    logic [DW-1:0] pack_data;
    logic [DW-1:0] pack_next;
    logic [DW-1:0] buf1;
    logic [CW-1:0] committed;
    logic [CW-1:0] avail;
    logic          pop;
    logic          done_ok;
    logic          push;
    logic          full_drop;

    assign o_valid = (o_level != 2'd0);
    assign pop     = o_valid & i_ready;
    assign done_ok = i_fifo_rd_done & inflight;

    // Everything already owed to the buffer, counted in FIFO words; a pop this
    // cycle frees one wide slot so reads can continue back-to-back.
    assign committed = CW'(o_level) * RATIO_C + CW'(pack_cnt) + CW'(inflight);
    assign avail     = committed - (pop ? RATIO_C : '0);
    assign o_fifo_rd = i_rst_n & ~i_fifo_empty & (avail < LIMIT);

    always_comb begin
        pack_next = pack_data;
        for (int k = 0; k < G_RATIO; k++) begin
            if (pack_cnt == PW'(k)) begin
                pack_next[k*G_WIDTH +: G_WIDTH] = i_fifo_data;
            end
        end
    end

    assign push      = done_ok & (pack_cnt == LAST);
    assign full_drop = push & (o_level == 2'd2) & ~pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pack_cnt  <= '0;
            inflight  <= 1'b0;
            pack_data <= '0;
            buf1      <= '0;
            o_data    <= '0;
            o_level   <= 2'd0;
            o_err     <= 1'b0;
        end else begin
            inflight <= o_fifo_rd | (inflight & ~i_fifo_rd_done);

            // A done with nothing outstanding is a stray pulse; its data is ignored.
            if (done_ok) begin
                if (push) begin
                    pack_cnt  <= '0;
                    pack_data <= '0;
                end else begin
                    pack_cnt  <= pack_cnt + PW'(1);
                    pack_data <= pack_next;
                end
            end

            if ((i_fifo_rd_done & ~inflight) | full_drop) begin
                o_err <= 1'b1;
            end

            case (o_level)
                2'd0: begin
                    if (push) begin
                        o_data  <= pack_next;
                        o_level <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push & pop) begin
                        o_data <= pack_next;
                    end else if (push) begin
                        buf1    <= pack_next;
                        o_level <= 2'd2;
                    end else if (pop) begin
                        o_level <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        o_data <= buf1;
                        if (push) begin
                            buf1 <= pack_next;
                        end else begin
                            o_level <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_packer.sv
// Directed bench for fifo_stream_packer: FIFO read model, output scoreboard,
// a table of pack groups and hand-written reset/backpressure/error sequences.
module tb_fifo_stream_packer;

    localparam int W = 8;
    localparam int R = 4;

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [7:0]  w2;
        logic [7:0]  w3;
        logic [31:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         model_done = 1'b0;
    logic         spur = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] fifo_data = '0;
    logic         rd_done;
    logic         fifo_rd;
    logic         valid;
    logic         err;
    logic [W*R-1:0] data;
    logic [1:0]   level;

    assign rd_done = model_done | spur;

    always #5 clk = ~clk;

    fifo_stream_packer #(.G_WIDTH(W), .G_RATIO(R)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .o_fifo_rd      (fifo_rd),
        .i_fifo_empty   (fifo_empty),
        .i_fifo_data    (fifo_data),
        .i_fifo_rd_done (rd_done),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_data         (data),
        .o_level        (level),
        .o_err          (err)
    );

    int checks = 0;
    int failures = 0;
    int n_reads = 0;
    int n_beats = 0;
    int cyc = 0;
    logic [7:0]  q[$];
    logic [31:0] exp_q[$];
    logic        pend = 1'b0;
    logic [7:0]  pend_data = '0;
    vec_t        tbl[6];

    logic        s_valid, s_rd, s_err;
    logic [31:0] s_data;
    logic [1:0]  s_level;
    int          s_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: sample at negedge (FIFO model + scoreboard), drive FIFO
    // response just after posedge, return at posedge+2 for stimulus.
    task automatic tick();
        @(negedge clk);
        s_valid = valid;
        s_rd    = fifo_rd;
        s_err   = err;
        s_data  = data;
        s_level = level;
        s_cyc   = cyc;
        pend    = 1'b0;
        if (fifo_rd) begin
            if (q.size() == 0) begin
                chk("rd_while_empty", 64'd1, 64'd0);
            end else begin
                pend_data = q.pop_front();
                pend      = 1'b1;
                n_reads++;
            end
        end
        if (valid && ready) begin
            n_beats++;
            if (exp_q.size() == 0) chk("beat_unexpected", {32'd0, data}, 64'hDEAD_0000_0000);
            else chk("beat_data", {32'd0, data}, {32'd0, exp_q.pop_front()});
        end
        @(posedge clk);
        cyc++;
        #1;
        model_done = pend;
        fifo_data  = pend ? pend_data : '0;
        fifo_empty = (q.size() == 0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd4, fv, b0, r0, nv;
        logic all_rd, have, stable;
        logic [31:0] snap;

        tbl[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
        tbl[1] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 32'hFF005AA5};
        tbl[2] = '{8'h01, 8'h02, 8'h04, 8'h08, 32'h08040201};
        tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
        tbl[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
        tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h80, 32'h80000000};

        // Reset then idle
        tick();
        chk("rst_valid", s_valid, 0);
        chk("rst_data", s_data, 0);
        chk("rst_level", s_level, 0);
        chk("rst_rd", s_rd, 0);
        chk("rst_err", s_err, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_rd", s_rd, 0);
        end
        chk("idle_reads", n_reads, 0);

        // Single pack with latency
        ready = 1'b1;
        exp_q.push_back(tbl[0].exp);
        push_word(tbl[0].w0); push_word(tbl[0].w1);
        push_word(tbl[0].w2); push_word(tbl[0].w3);
        rd4 = -1; fv = -1; b0 = n_beats;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (n_reads == 4 && rd4 < 0) rd4 = s_cyc;
            if (s_valid && fv < 0) fv = s_cyc;
        end
        chk("single_latency", 64'(fv - rd4), 64'd2);
        chk("single_reads", n_reads, 4);
        chk("single_beats", n_beats - b0, 1);
        chk("single_rd_after", s_rd, 0);
        chk("single_exp_left", exp_q.size(), 0);

        // Backpressure: buffer fills to 2, reads stop at 8 words committed
        ready = 1'b0;
        r0 = n_reads; b0 = n_beats;
        for (int k = 1; k <= 16; k++) push_word(8'(k * 17));
        have = 1'b0; stable = 1'b1; snap = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_valid) begin
                if (!have) begin snap = s_data; have = 1'b1; end
                else if (s_data !== snap) stable = 1'b0;
            end
        end
        chk("bp_level", s_level, 2);
        chk("bp_data", s_data, 32'h44332211);
        chk("bp_reads", n_reads - r0, 8);
        chk("bp_rd_stopped", s_rd, 0);
        chk("bp_stable", stable, 1);
        exp_q.push_back(32'h44332211);
        exp_q.push_back(32'h88776655);
        exp_q.push_back(32'hCCBBAA99);
        exp_q.push_back(32'h10FFEEDD);
        ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        chk("bp_exp_left", exp_q.size(), 0);
        chk("bp_beats", n_beats - b0, 4);
        chk("bp_level_end", s_level, 0);
        chk("bp_err", s_err, 0);

        // Streaming from the vector table
        b0 = n_beats;
        for (int g = 0; g < 6; g++) begin
            push_word(tbl[g].w0); push_word(tbl[g].w1);
            push_word(tbl[g].w2); push_word(tbl[g].w3);
            exp_q.push_back(tbl[g].exp);
        end
        for (int i = 0; i < 4; i++) tick();
        all_rd = 1'b1; nv = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!s_rd) all_rd = 1'b0;
            if (s_valid) nv++;
        end
        chk("stream_rd_every_cycle", all_rd, 1);
        chk("stream_valid_1_in_4", nv, 4);
        for (int i = 0; i < 20; i++) tick();
        chk("stream_exp_left", exp_q.size(), 0);
        chk("stream_beats", n_beats - b0, 6);
        chk("stream_err", s_err, 0);

        // Reset mid-pack discards the partial group
        push_word(8'h55); push_word(8'h66);
        for (int i = 0; i < 6; i++) tick();
        chk("midpack_level", s_level, 0);
        rst_n = 1'b0;
        push_word(8'hA1); push_word(8'hA2); push_word(8'hA3); push_word(8'hA4);
        tick();
        chk("midpack_rst_rd", s_rd, 0);
        tick();
        chk("midpack_rst_rd2", s_rd, 0);
        chk("midpack_rst_valid", s_valid, 0);
        rst_n = 1'b1;
        b0 = n_beats;
        exp_q.push_back(32'hA4A3A2A1);
        for (int i = 0; i < 12; i++) tick();
        chk("midpack_exp_left", exp_q.size(), 0);
        chk("midpack_beats", n_beats - b0, 1);
        chk("midpack_err", s_err, 0);

        // Stray read-done raises a sticky error
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        chk("err_set", s_err, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("err_sticky", s_err, 1);
        chk("err_no_push", s_level, 0);
        rst_n = 1'b0;
        tick();
        chk("err_cleared", s_err, 0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
